hls_deadlock_param_monitor: RTL and testbench
=============================================

HLS_DEADLOCK_PARAM_MONITOR -- requirements
Module: hls_deadlock_param_monitor

Interface
REQ-001 Parameter NUM_AXIS, default 10, width of axis_block_sigs (range 1..64).
REQ-002 Parameter NUM_IDLE, default 5, width of inst_idle_sigs (range 1..32).
REQ-003 Parameter NUM_INST, default 1, width of inst_block_sigs (range 1..32).
REQ-004 Parameter WATCH_MASK, default 10'h380, NUM_AXIS bits; 1 = axis bit participates in detection.
REQ-005 Parameter THRESH, default 1, consecutive blocked cycles before flag (range 1..2^16-1).
REQ-006 clock  input  1  rising-edge clock.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 axis_block_sigs  input  NUM_AXIS  per-AXIS-port blocked indication.
REQ-009 inst_idle_sigs  input  NUM_IDLE  per-sub-instance idle indication.
REQ-010 inst_block_sigs  input  NUM_INST  per-sub-monitor block indication.
REQ-011 clear  input  1  single-cycle release of a latched block.
REQ-012 block  output  1  deadlock detected, registered.
REQ-013 block_src  output  clog2(NUM_AXIS+NUM_INST)  source index latched on entry to BLOCKED.
REQ-014 block_events  output  8  saturating count of BLOCKED entries.

Function
REQ-015 blk_now = (|(axis_block_sigs & WATCH_MASK) | |inst_block_sigs) & ~(&inst_idle_sigs); combinational, sampled each edge.
REQ-016 States: S_IDLE, S_ARMED, S_BLOCKED; 16-bit run counter cnt.
REQ-017 S_IDLE: blk_now=1 and THRESH=1 -> S_BLOCKED; blk_now=1 and THRESH>1 -> S_ARMED, cnt<=1; else stay, cnt<=0.
REQ-018 S_ARMED: blk_now=0 -> S_IDLE, cnt<=0; blk_now=1 and cnt==THRESH-1 -> S_BLOCKED; else cnt<=cnt+1.
REQ-019 block SHALL be 1 exactly when state is S_BLOCKED; first high in the cycle after the THRESH-th consecutive sampled blk_now=1.
REQ-020 THRESH=1 SHALL give single-cycle-latency behaviour: block follows blk_now delayed one clock (non-sticky build).
REQ-021 On S_BLOCKED entry, block_src <= lowest index set in {inst_block_sigs, axis_block_sigs & WATCH_MASK}, axis bits indices 0..NUM_AXIS-1, inst bits NUM_AXIS..; block_src otherwise held.
REQ-022 On S_BLOCKED entry, block_events increments, saturating at 255.
REQ-023 S_BLOCKED exit (non-sticky): blk_now=0 -> S_IDLE, cnt<=0.
REQ-024 clear=1 in S_BLOCKED SHALL force S_IDLE next cycle, overriding blk_now; clear in other states ignored.
REQ-025 All-idle inst_idle_sigs SHALL mask detection even when block inputs are high.
REQ-026 Re-entry after exit SHALL require a fresh THRESH-cycle run.

Reset
REQ-027 reset=1 at an edge: state<=S_IDLE, cnt<=0, block<=0, block_src<=0, block_events<=0; priority over all inputs, including mid-run and in S_BLOCKED.

Configuration
REQ-028 Macro DEADLOCK_MON_STICKY_EN defined: S_BLOCKED exits only on clear or reset; blk_now=0 does not release.
REQ-029 Macro undefined: exit per REQ-023 and REQ-024.

Verification
REQ-030 Defaults, non-sticky: axis_block_sigs=10'h080 for one cycle -> block=1 next cycle only, block_src=7, block_events=1.
REQ-031 THRESH=4: axis bit 8 high 3 cycles, low 1, high 4 -> block high only after the 4th cycle of the second run, block_events=1.
REQ-032 Mask: axis_block_sigs=10'h07F held 20 cycles -> block stays 0; inst_block_sigs=1 -> block=1, block_src=10.
REQ-033 Idle mask: axis bit 9 high, inst_idle_sigs=5'h1F -> block=0; idle drops to 5'h1E -> block=1 after THRESH cycles.
REQ-034 Sticky build: block asserted, inputs drop to 0 -> block remains 1; clear pulse -> block=0 next cycle.
REQ-035 Reset in S_ARMED with cnt=2 and in S_BLOCKED -> all outputs 0 next cycle; 256 block entries -> block_events=255.

Source files
------------

// File: rtl/hls_deadlock_param_monitor.sv
// hls_deadlock_param_monitor
//   Watches AXIS-port and sub-monitor block indications and flags a deadlock
//   once blocking has been seen for THRESH consecutive cycles, unless every
//   sub-instance reports idle.
//
//   Optional build macro: DEADLOCK_MON_STICKY_EN. When it is defined, a
//   detected block is held until clear or reset.
//
// Ports
//   clock            rising-edge clock
//   reset            synchronous, active-high reset
//   axis_block_sigs  [NUM_AXIS]  per-AXIS-port blocked indication
//   inst_idle_sigs   [NUM_IDLE]  per-sub-instance idle indication
//   inst_block_sigs  [NUM_INST]  per-sub-monitor block indication
//   clear            single-cycle release of a latched block
//   block            deadlock detected (registered)
//   block_src        lowest source index latched on entry to BLOCKED
//                    (axis bits 0..NUM_AXIS-1, then inst bits)
//   block_events     saturating count of BLOCKED entries
module hls_deadlock_param_monitor #(
  parameter int unsigned          NUM_AXIS   = 10,
  parameter int unsigned          NUM_IDLE   = 5,
  parameter int unsigned          NUM_INST   = 1,
  parameter logic [NUM_AXIS-1:0]  WATCH_MASK = 10'h380,
  parameter int unsigned          THRESH     = 1,
  localparam int unsigned         SRC_N      = NUM_AXIS + NUM_INST,
  localparam int unsigned         SRC_W      = (SRC_N > 1) ? $clog2(SRC_N) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic [NUM_IDLE-1:0] inst_idle_sigs,
  input  logic [NUM_INST-1:0] inst_block_sigs,
  input  logic                clear,
  output logic                block,
  output logic [SRC_W-1:0]    block_src,
  output logic [7:0]          block_events
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_BLOCKED = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [15:0]     cnt, cnt_next;
  logic            blk_now;
  logic            enter_blocked;
  logic [SRC_N-1:0] cand;
  logic [SRC_W-1:0] src_next;

  assign cand    = {inst_block_sigs, axis_block_sigs & WATCH_MASK};
  assign blk_now = (|(axis_block_sigs & WATCH_MASK) | (|inst_block_sigs))
                   & ~(&inst_idle_sigs);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    src_next = '0;
    for (int unsigned i = SRC_N; i > 0; i--) begin
      if (cand[i-1]) src_next = SRC_W'(i - 1);
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        if (blk_now) begin
          if (THRESH == 1) begin
            state_next = S_BLOCKED;
            cnt_next   = '0;
          end else begin
            state_next = S_ARMED;
            cnt_next   = 16'd1;
          end
        end else begin
          cnt_next = '0;
        end
      end
      S_ARMED: begin
        if (!blk_now) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end else if (cnt == 16'(THRESH - 1)) begin
          state_next = S_BLOCKED;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 16'd1;
        end
      end
      S_BLOCKED: begin
        if (clear) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end
`ifdef DEADLOCK_MON_STICKY_EN
`else
        else if (!blk_now) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end
`endif
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign enter_blocked = (state != S_BLOCKED) && (state_next == S_BLOCKED);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      block        <= 1'b0;
      block_src    <= '0;
      block_events <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      // block mirrors the registered state, so it is derived from state_next.
      block <= (state_next == S_BLOCKED);
      if (enter_blocked) begin
        block_src <= src_next;
        if (block_events != 8'hFF) block_events <= block_events + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_hls_deadlock_param_monitor.sv
// Testbench for hls_deadlock_param_monitor: two instances share stimulus,
// one with default parameters (THRESH=1) and one with THRESH=4. Each output
// is compared every cycle against a run-length reference model.
module tb_hls_deadlock_param_monitor;

`ifdef DEADLOCK_MON_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif
  localparam logic [9:0] MASK = 10'h380;

  logic       clock = 1'b0;
  logic       reset;
  logic [9:0] axis_block_sigs;
  logic [4:0] inst_idle_sigs;
  logic [0:0] inst_block_sigs;
  logic       clear;

  logic       block_a, block_b;
  logic [3:0] src_a, src_b;
  logic [7:0] ev_a, ev_b;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  hls_deadlock_param_monitor dut_a (
    .clock(clock), .reset(reset), .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs),
    .clear(clear), .block(block_a), .block_src(src_a), .block_events(ev_a)
  );

  hls_deadlock_param_monitor #(.THRESH(4)) dut_b (
    .clock(clock), .reset(reset), .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs),
    .clear(clear), .block(block_b), .block_src(src_b), .block_events(ev_b)
  );

  // Reference model state, index 0 = dut_a, 1 = dut_b.
  int thresh [2] = '{1, 4};
  int run    [2];
  bit blocked[2];
  int src    [2];
  int events [2];

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic [9:0] a, input logic [4:0] id,
                            input logic [0:0] in, input logic c, input logic r);
    bit b;
    int low;
    logic [10:0] w;
    w   = {in, a & MASK};
    b   = (w != 0) && (id != 5'h1F);
    low = 0;
    for (int i = 10; i >= 0; i--) if (w[i]) low = i;
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        blocked[k] = 0; run[k] = 0; src[k] = 0; events[k] = 0;
      end else if (blocked[k]) begin
        if (c || (!STICKY && !b)) begin
          blocked[k] = 0; run[k] = 0;
        end
      end else if (b) begin
        run[k]++;
        if (run[k] >= thresh[k]) begin
          blocked[k] = 1;
          run[k]     = 0;
          src[k]     = low;
          if (events[k] < 255) events[k]++;
        end
      end else begin
        run[k] = 0;
      end
    end
  endtask

  task automatic step(input logic [9:0] a, input logic [4:0] id,
                      input logic [0:0] in, input logic c, input logic r);
    axis_block_sigs = a;
    inst_idle_sigs  = id;
    inst_block_sigs = in;
    clear           = c;
    reset           = r;
    model_edge(a, id, in, c, r);
    @(posedge clock);
    #1;
    check_eq("a.block",  int'(block_a), int'(blocked[0]));
    check_eq("a.src",    int'(src_a),   src[0]);
    check_eq("a.events", int'(ev_a),    events[0]);
    check_eq("b.block",  int'(block_b), int'(blocked[1]));
    check_eq("b.src",    int'(src_b),   src[1]);
    check_eq("b.events", int'(ev_b),    events[1]);
  endtask

  initial begin
    logic [9:0] ra;
    logic [4:0] rid;
    logic [0:0] rin;
    int         hold;

    // Reset state
    step('0, '0, '0, 1'b0, 1'b1);
    step('0, '0, '0, 1'b0, 1'b1);
    step('0, '0, '0, 1'b0, 1'b0);

    // Single blocked cycle on axis bit 7
    step(10'h080, '0, '0, 1'b0, 1'b0);
    step(10'h000, '0, '0, 1'b0, 1'b0);
    step(10'h000, '0, '0, 1'b1, 1'b0);
    step(10'h000, '0, '0, 1'b0, 1'b0);

    // THRESH=4 run broken after 3 cycles, then a full run
    step('0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(10'h100, '0, '0, 1'b0, 1'b0);
    step(10'h000, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(10'h100, '0, '0, 1'b0, 1'b0);
    step(10'h000, '0, '0, 1'b1, 1'b0);
    step(10'h000, '0, '0, 1'b0, 1'b0);

    // Unwatched bits never block; inst block source index 10
    for (int i = 0; i < 20; i++) step(10'h07F, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)  step(10'h07F, '0, 1'b1, 1'b0, 1'b0);
    step(10'h000, '0, '0, 1'b1, 1'b0);
    step(10'h000, '0, '0, 1'b0, 1'b0);

    // All-idle masks detection, then idle drops
    for (int i = 0; i < 8; i++) step(10'h200, 5'h1F, '0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(10'h200, 5'h1E, '0, 1'b0, 1'b0);
    // Inputs drop while blocked (held only in the sticky build), then clear
    for (int i = 0; i < 3; i++) step(10'h000, 5'h00, '0, 1'b0, 1'b0);
    step(10'h000, '0, '0, 1'b1, 1'b0);
    step(10'h000, '0, '0, 1'b0, 1'b0);
    // Clear while still blocking: fresh run required to re-enter
    for (int i = 0; i < 5; i++) step(10'h300, '0, '0, 1'b0, 1'b0);
    step(10'h300, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(10'h300, '0, '0, 1'b0, 1'b0);

    // Reset mid-run (dut_b armed with cnt=2) and while blocked
    step('0, '0, '0, 1'b0, 1'b1);
    step(10'h080, '0, '0, 1'b0, 1'b0);
    step(10'h080, '0, '0, 1'b0, 1'b0);
    step(10'h080, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(10'h080, '0, '0, 1'b0, 1'b0);
    step(10'h080, '0, '0, 1'b0, 1'b1);
    step(10'h000, '0, '0, 1'b0, 1'b0);

    // Event counter saturation: 300 enter/clear pairs on dut_a
    for (int i = 0; i < 300; i++) begin
      step(10'h080, '0, '0, 1'b0, 1'b0);
      step(10'h000, '0, '0, 1'b1, 1'b0);
    end
    check_eq("a.events_sat", int'(ev_a), 255);

    // Randomized stimulus held for 1..6 cycles at a time
    step('0, '0, '0, 1'b0, 1'b1);
    for (int n = 0; n < 600; n++) begin
      ra   = 10'($urandom & $urandom);
      rid  = ($urandom_range(0, 4) == 0) ? 5'h1F : 5'($urandom);
      rin  = 1'($urandom_range(0, 7) == 0);
      hold = $urandom_range(1, 6);
      for (int h = 0; h < hold; h++)
        step(ra, rid, rin, $urandom_range(0, 7) == 0,
             $urandom_range(0, 199) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
